pipeline_hazard_ctrl: RTL



---
 rtl/pipeline_hazard_ctrl_if.sv | 44 ++++
 rtl/pipeline_hazard_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline status in, register sequencing controls out, for pipeline_hazard_ctrl.
// master = pipeline/datapath side, slave = hazard controller side.
interface pipeline_hazard_ctrl_if;
  logic [4:0]  ID_Rn;
  logic [4:0]  ID_Rm;
  logic        ID_uses_Rn;
  logic        ID_uses_Rm;
  logic        EX_MemRead;
  logic [4:0]  EX_Write_Reg;
  logic        EX_br_taken;
  logic        MEM_MemRead;
  logic        MEM_MemWrite;
  logic        mem_ready;

  logic        PC_wr_en;
  logic        IF_ID_wr_en;
  logic        ID_EX_wr_en;
  logic        EX_MEM_wr_en;
  logic        PC_sel_branch;
  logic        IF_ID_flush;
  logic        ID_EX_flush;
  logic        MEM_WB_flush;
  logic        mem_req;
  logic        stall_active;
  logic        mem_timeout;
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;

  modport master (
    output ID_Rn, ID_Rm, ID_uses_Rn, ID_uses_Rm, EX_MemRead, EX_Write_Reg,
           EX_br_taken, MEM_MemRead, MEM_MemWrite, mem_ready,
    input  PC_wr_en, IF_ID_wr_en, ID_EX_wr_en, EX_MEM_wr_en, PC_sel_branch,
           IF_ID_flush, ID_EX_flush, MEM_WB_flush, mem_req, stall_active,
           mem_timeout, stall_cycles, flush_count
  );

  modport slave (
    input  ID_Rn, ID_Rm, ID_uses_Rn, ID_uses_Rm, EX_MemRead, EX_Write_Reg,
           EX_br_taken, MEM_MemRead, MEM_MemWrite, mem_ready,
    output PC_wr_en, IF_ID_wr_en, ID_EX_wr_en, EX_MEM_wr_en, PC_sel_branch,
           IF_ID_flush, ID_EX_flush, MEM_WB_flush, mem_req, stall_active,
           mem_timeout, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage pipeline sequencer: load-use stall, EX branch squash, data-memory wait with timeout.
// Define HAZ_PERF_CNT_EN to build the saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input logic                  clk,
  input logic                  reset,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_e;

  localparam logic [8:0] TIMEOUT = 9'(MEM_TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [8:0] wait_cnt_inc;

  logic load_use, mem_hold;
  logic pc_we, ifid_we, idex_we, exmem_we;
  logic sel_br, ifid_fl, idex_fl, memwb_fl, req;
  logic pc_we_g, ifid_we_g, idex_we_g, exmem_we_g;
  logic ifid_fl_g, idex_fl_g, stall_act;

  // X31 is the zero register, so a load "into" it never feeds a consumer.
  always_comb begin
    load_use = hz.EX_MemRead && (hz.EX_Write_Reg != 5'd31) &&
               ((hz.ID_uses_Rn && (hz.ID_Rn == hz.EX_Write_Reg)) ||
                (hz.ID_uses_Rm && (hz.ID_Rm == hz.EX_Write_Reg)));
    mem_hold = (state_q != ERROR) && !hz.mem_ready &&
               ((state_q == MEM_WAIT) || hz.MEM_MemRead || hz.MEM_MemWrite);
    wait_cnt_inc = {1'b0, wait_cnt_q} + 9'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN: begin
        if (mem_hold) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (hz.mem_ready) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_inc[7:0];
          // Counter already includes the low-ready cycle seen in RUN.
          if (wait_cnt_inc == TIMEOUT) state_d = ERROR;
        end
      end
      default: ;
    endcase
  end

  // Release cycle of MEM_WAIT falls through to the same branch/load-use chain as RUN.
  always_comb begin
    pc_we    = 1'b1;
    ifid_we  = 1'b1;
    idex_we  = 1'b1;
    exmem_we = 1'b1;
    sel_br   = 1'b0;
    ifid_fl  = 1'b0;
    idex_fl  = 1'b0;
    memwb_fl = 1'b0;
    req      = hz.MEM_MemRead | hz.MEM_MemWrite;
    case (state_q)
      ERROR: begin
        pc_we    = 1'b0;
        ifid_we  = 1'b0;
        idex_we  = 1'b0;
        exmem_we = 1'b0;
        memwb_fl = 1'b1;
        req      = 1'b0;
      end
      default: begin
        if (state_q == MEM_WAIT) req = 1'b1;
        if (mem_hold) begin
          pc_we    = 1'b0;
          ifid_we  = 1'b0;
          idex_we  = 1'b0;
          exmem_we = 1'b0;
          memwb_fl = 1'b1;
          req      = 1'b1;
        end else if (hz.EX_br_taken) begin
          sel_br  = 1'b1;
          ifid_fl = 1'b1;
          idex_fl = 1'b1;
        end else if (load_use) begin
          pc_we   = 1'b0;
          ifid_we = 1'b0;
          idex_fl = 1'b1;
        end
      end
    endcase
  end

  // Reset holds every register quiet regardless of state or inputs.
  always_comb begin
    pc_we_g    = pc_we    & reset;
    ifid_we_g  = ifid_we  & reset;
    idex_we_g  = idex_we  & reset;
    exmem_we_g = exmem_we & reset;
    ifid_fl_g  = ifid_fl  & reset;
    idex_fl_g  = idex_fl  & reset;
    stall_act  = !(pc_we_g & ifid_we_g & idex_we_g & exmem_we_g);
  end

  assign hz.PC_wr_en      = pc_we_g;
  assign hz.IF_ID_wr_en   = ifid_we_g;
  assign hz.ID_EX_wr_en   = idex_we_g;
  assign hz.EX_MEM_wr_en  = exmem_we_g;
  assign hz.PC_sel_branch = sel_br & reset;
  assign hz.IF_ID_flush   = ifid_fl_g;
  assign hz.ID_EX_flush   = idex_fl_g;
  assign hz.MEM_WB_flush  = memwb_fl & reset;
  assign hz.mem_req       = req & reset;
  assign hz.stall_active  = stall_act;
  assign hz.mem_timeout   = (state_q == ERROR);

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (stall_act && (stall_cycles_q != '1))
      stall_cycles_d = stall_cycles_q + 32'd1;
    if ((ifid_fl_g | idex_fl_g) && (flush_count_q != '1))
      flush_count_d = flush_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign hz.stall_cycles = stall_cycles_q;
  assign hz.flush_count  = flush_count_q;
`else
  assign hz.stall_cycles = '0;
  assign hz.flush_count  = '0;
`endif

endmodule
